// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx: oversampling UART receiver, 3-sample majority vote at mid-bit,  |
// | optional parity. Define UART_RX_SYNC_EN to add a 2-flop RX synchroniser. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};
  end
  assign rx = sync[1];
`else
  assign rx = rx_in;
`endif

  state_t                state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0]     shift;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  pen_q;
  logic                  typ_q;
  logic                  samp0;
  logic                  samp1;
  logic                  par_fail;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] mid_lo;
  logic [PRESCALE_W-1:0] mid_hi;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  at_vote;
  logic                  at_last;
  logic                  vote;
  logic                  exp_par;

  assign half      = presc_q >> 1;
  assign mid_lo    = half - PRESCALE_W'(1);
  assign mid_hi    = half + PRESCALE_W'(1);
  assign last_edge = presc_q - PRESCALE_W'(1);
  assign at_vote   = (edge_cnt == mid_hi);
  assign at_last   = (edge_cnt == last_edge);
  // Third sample is the live line value on the voting cycle.
  assign vote      = (samp0 & samp1) | (samp0 & rx) | (samp1 & rx);
  assign exp_par   = (^shift) ^ typ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      presc_q    <= '0;
      pen_q      <= 1'b0;
      typ_q      <= 1'b0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      par_fail   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state != S_IDLE) begin
        edge_cnt <= at_last ? '0 : edge_cnt + PRESCALE_W'(1);
        if (edge_cnt == mid_lo) samp0 <= rx;
        if (edge_cnt == half)   samp1 <= rx;
      end

      case (state)
        S_IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          par_fail <= 1'b0;
          if (!rx) begin
            state   <= S_START;
            presc_q <= prescale;
            pen_q   <= par_en;
            typ_q   <= par_typ;
          end
        end

        S_START: begin
          if (at_vote && vote) state <= S_IDLE;
          else if (at_last)    state <= S_DATA;
        end

        S_DATA: begin
          if (at_vote) shift <= {vote, shift[DATA_W-1:1]};
          if (at_last) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= pen_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (at_vote) par_fail <= (vote != exp_par);
          if (at_last) state <= S_STOP;
        end

        // Leave after half the stop bit so a back-to-back start edge is caught.
        S_STOP: begin
          if (at_vote) begin
            state <= S_IDLE;
            if (vote && !par_fail) begin
              p_data     <= shift;
              data_valid <= 1'b1;
            end
            par_err <= par_fail;
            stp_err <= !vote;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for uart_rx: table of frames driven onto the line, strobes checked
// against a queue of expected results including their arrival cycle.
module tb_uart_rx;
  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int NVEC = 9;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rx_in = 1'b1;
  logic [PRESCALE_W-1:0] prescale = 6'd8;
  logic                  par_en = 1'b0;
  logic                  par_typ = 1'b0;
  logic [DATA_W-1:0]     p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  uart_rx #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #2.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         flip;
    bit         stop;
    int         gap;
    bit         e_valid;
    bit         e_perr;
    bit         e_serr;
    logic [7:0] e_data;
  } vec_t;

  typedef struct {
    bit         valid;
    bit         perr;
    bit         serr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   exp_valid_cnt = 0;

  function automatic vec_t mk(int p, bit pe, bit pt, logic [7:0] data, bit flip, bit stop,
                              int gap, bit ev, bit ep, bit es, logic [7:0] ed);
    vec_t v;
    v.p = p; v.pe = pe; v.pt = pt; v.data = data; v.flip = flip; v.stop = stop;
    v.gap = gap; v.e_valid = ev; v.e_perr = ep; v.e_serr = es; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    exp_t       e;
    logic [7:0] d;
    logic       par;
    d        = v.data;
    prescale = PRESCALE_W'(v.p);
    par_en   = v.pe;
    par_typ  = v.pt;
    if (v.e_valid || v.e_perr || v.e_serr) begin
      e.valid = v.e_valid;
      e.perr  = v.e_perr;
      e.serr  = v.e_serr;
      e.data  = v.e_data;
      e.due   = cyc + 1 + v.p * (9 + int'(v.pe)) + v.p / 2 + 2 + SYNC_LAT;
      sb.push_back(e);
    end
    drive_bit(1'b0, v.p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], v.p);
    if (v.pe) begin
      par = (^d) ^ v.pt ^ v.flip;
      drive_bit(par, v.p);
    end
    drive_bit(v.stop, v.p);
    rx_in = 1'b1;
    repeat (v.gap) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (data_valid || par_err || stp_err)) begin
        if (data_valid) n_valid++;
        chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("data_valid", 32'(data_valid), 32'(e.valid));
          chk("par_err",    32'(par_err),    32'(e.perr));
          chk("stp_err",    32'(stp_err),    32'(e.serr));
          chk("p_data",     32'(p_data),     32'(e.data));
          chk("latency",    32'(cyc),        32'(e.due));
        end
      end
    end
  endtask

  initial begin
    //           P  pe pt data   flip stop gap  v  pe se exp_data
    vecs[0] = mk(8,  1, 0, 8'hAB, 0, 1,  0,  1, 0, 0, 8'hAB);
    vecs[1] = mk(8,  1, 1, 8'h4C, 0, 1,  24, 1, 0, 0, 8'h4C);
    vecs[2] = mk(16, 0, 0, 8'h0F, 0, 1,  48, 1, 0, 0, 8'h0F);
    vecs[3] = mk(8,  1, 1, 8'h83, 1, 1,  24, 0, 1, 0, 8'h0F);
    vecs[4] = mk(8,  1, 1, 8'h83, 0, 0,  24, 0, 0, 1, 8'h0F);
    vecs[5] = mk(8,  1, 0, 8'h5A, 1, 0,  24, 0, 1, 1, 8'h0F);
    vecs[6] = mk(32, 1, 0, 8'h3C, 0, 1,  96, 1, 0, 0, 8'h3C);
    vecs[7] = mk(8,  0, 1, 8'h00, 0, 1,  24, 1, 0, 0, 8'h00);
    vecs[8] = mk(16, 1, 1, 8'hFF, 0, 1,  48, 1, 0, 0, 8'hFF);

    repeat (3) @(negedge clk);
    chk("reset_p_data",     32'(p_data),     32'h0);
    chk("reset_data_valid", 32'(data_valid), 32'h0);
    chk("reset_par_err",    32'(par_err),    32'h0);
    chk("reset_stp_err",    32'(stp_err),    32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    fork
      monitor();
    join_none

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].e_valid) exp_valid_cnt++;
      send_frame(vecs[i]);
    end

    // Two-cycle glitch must be rejected, then a real frame accepted.
    prescale = 6'd8;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (24) @(negedge clk);
    send_frame(mk(8, 0, 0, 8'h55, 0, 1, 24, 1, 0, 0, 8'h55));
    exp_valid_cnt++;

    // Reset in the middle of data bit 4 of 0xF0.
    prescale = 6'd8;
    par_en   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_p_data",     32'(p_data),     32'h0);
    chk("midrst_data_valid", 32'(data_valid), 32'h0);
    chk("midrst_par_err",    32'(par_err),    32'h0);
    chk("midrst_stp_err",    32'(stp_err),    32'h0);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    send_frame(mk(8, 0, 0, 8'hF0, 0, 1, 24, 1, 0, 0, 8'hF0));
    exp_valid_cnt++;

    repeat (64) @(negedge clk);
    chk("pending_strobes", 32'(sb.size()), 32'd0);
    chk("valid_count",     32'(n_valid),   32'(exp_valid_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
